// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multi-cycle MULT/DIV sequencer owning the HI/LO registers
// Results are computed at issue and held pending; the counter only models latency.
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [3:0] MULT_N   = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N    = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        elapsed_q, elapsed_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        accept;

  logic [63:0] prod_s, prod_u;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, quo_mag, rem_mag, quo, rem;

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000, remainder 0.
  always_comb begin
    prod_s  = {{32{src0[31]}}, src0} * {{32{src1[31]}}, src1};
    prod_u  = {32'b0, src0} * {32'b0, src1};
    neg_a   = (op == OP_DIV) & src0[31];
    neg_b   = (op == OP_DIV) & src1[31];
    mag_a   = neg_a ? -src0 : src0;
    mag_b   = neg_b ? -src1 : src1;
    quo_mag = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
    rem_mag = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
    quo     = (neg_a ^ neg_b) ? -quo_mag : quo_mag;
    rem     = neg_a ? -rem_mag : rem_mag;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    elapsed_d = elapsed_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    accept    = 1'b0;

    case (state_q)
      IDLE: accept = 1'b1;
      RUN: begin
        if (!elapsed_q && cancel) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          elapsed_d = 1'b1;
          cnt_d     = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
            accept  = 1'b1;
            if (pend_wr_q) begin
              hi_d = pend_hi_q;
              lo_d = pend_lo_q;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // An issue on the commit edge is younger than the committing op, so it writes last.
    if (accept && start && !cancel) begin
      case (op)
        OP_MULT, OP_MULTU: begin
          state_d   = RUN;
          cnt_d     = MULT_N;
          elapsed_d = 1'b0;
          pend_wr_d = 1'b1;
          pend_hi_d = (op == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
          pend_lo_d = (op == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
        end
        OP_DIV, OP_DIVU: begin
          state_d   = RUN;
          cnt_d     = DIV_N;
          elapsed_d = 1'b0;
          pend_wr_d = (src1 != 32'd0);
          pend_hi_d = rem;
          pend_lo_d = quo;
        end
        OP_MTHI: hi_d = src0;
        OP_MTLO: lo_d = src0;
        default: ;
      endcase
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      elapsed_q <= 1'b0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      elapsed_q <= elapsed_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - randomized bench for muldiv_ctrl against a timeline model
// The model tracks each op by its issue/finish edge numbers and uses 64-bit integer arithmetic.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src0, src1;
  logic        cancel;
  logic        busy, done;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src0(src0), .src1(src1),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  int total = 0;
  int bad   = 0;

  int          edge_no;
  int          op_issue;
  int          op_end;
  bit          op_live;
  bit          m_done;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_wr;
  int          nbusy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  task automatic calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    p_wr = 1'b1;
    p = 64'd0;
    case (o)
      3'd1: begin q = sa * sb; p = 64'(q); end
      3'd2: p = ua * ub;
      3'd3: begin
        if (b == 32'd0) p_wr = 1'b0;
        else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
      end
      default: begin
        if (b == 32'd0) p_wr = 1'b0;
        else begin p[31:0] = 32'(ua / ub); p[63:32] = 32'(ua % ub); end
      end
    endcase
    p_hi = p[63:32];
    p_lo = p[31:0];
  endtask

  task automatic model_reset();
    op_live = 1'b0;
    m_done  = 1'b0;
    m_hi    = 32'd0;
    m_lo    = 32'd0;
  endtask

  task automatic model_edge();
    bit free;
    edge_no++;
    m_done = 1'b0;
    free = !op_live;
    if (op_live) begin
      if (edge_no == op_issue + 1 && cancel) op_live = 1'b0;
      else if (edge_no == op_end) begin
        op_live = 1'b0;
        m_done  = 1'b1;
        free    = 1'b1;
        if (p_wr) begin m_hi = p_hi; m_lo = p_lo; end
      end
    end
    if (free && start && !cancel) begin
      case (op)
        3'd1, 3'd2, 3'd3, 3'd4: begin
          calc(op, src0, src1);
          op_live  = 1'b1;
          op_issue = edge_no;
          op_end   = edge_no + ((op <= 3'd2) ? 5 : 10);
        end
        3'd5: m_hi = src0;
        3'd6: m_lo = src0;
        default: ;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("busy", {31'b0, busy}, {31'b0, op_live});
    check("done", {31'b0, done}, {31'b0, m_done});
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    nbusy += int'(busy);
  endtask

  task automatic drive(input logic s, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic c);
    start = s; op = o; src0 = a; src1 = b; cancel = c;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'd0, $urandom, $urandom, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    edge_no = 0; op_issue = 0; op_end = 0; nbusy = 0;
    p_wr = 1'b0; p_hi = 32'd0; p_lo = 32'd0;
    model_reset();
    reset = 1'b0; start = 1'b0; op = 3'd0; src0 = 32'd0; src1 = 32'd0; cancel = 1'b0;
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b1;

    drive(1'b1, 3'd1, 32'hFFFF_FFFF, 32'h2, 1'b0);
    idle(5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);

    drive(1'b1, 3'd2, 32'hFFFF_FFFF, 32'h2, 1'b0);
    idle(5);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    drive(1'b1, 3'd3, 32'hFFFF_FFF9, 32'h2, 1'b0);
    idle(10);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lo", lo, 32'hFFFF_FFFD);

    drive(1'b1, 3'd4, 32'd7, 32'd0, 1'b0);
    idle(10);
    check("divz_hi", hi, 32'hFFFF_FFFF);
    check("divz_lo", lo, 32'hFFFF_FFFD);

    drive(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(10);
    check("divov_hi", hi, 32'h0);
    check("divov_lo", lo, 32'h8000_0000);

    drive(1'b1, 3'd1, 32'd3, 32'd3, 1'b1);
    check("cancel_issue_busy", {31'b0, busy}, 32'd0);
    idle(2);

    drive(1'b1, 3'd1, 32'd5, 32'd5, 1'b0);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    check("cancel_early_busy", {31'b0, busy}, 32'd0);
    idle(6);
    check("cancel_early_lo", lo, 32'h8000_0000);

    drive(1'b1, 3'd1, 32'd5, 32'd5, 1'b0);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    idle(3);
    check("cancel_late_lo", lo, 32'd25);

    drive(1'b1, 3'd5, 32'h1234_5678, 32'd0, 1'b0);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_busy", {31'b0, busy}, 32'd0);

    drive(1'b1, 3'd1, 32'd2, 32'd3, 1'b0);
    drive(1'b1, 3'd6, 32'hDEAD_BEEF, 32'd0, 1'b0);
    idle(4);
    check("mtlo_ignored_lo", lo, 32'd6);

    nbusy = 0;
    drive(1'b1, 3'd1, 32'd2, 32'd2, 1'b0);
    idle(4);
    drive(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
    check("b2b_mult_lo", lo, 32'd4);
    idle(10);
    check("b2b_busy_cycles", 32'(nbusy), 32'd15);
    check("b2b_div_lo", lo, 32'd14);

    drive(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
    idle(2);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    model_reset();
    #9 reset = 1'b1;
    drive(1'b1, 3'd1, 32'd3, 32'd4, 1'b0);
    idle(5);
    check("post_rst_hi", hi, 32'd0);
    check("post_rst_lo", lo, 32'd12);

    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), pick(), pick(),
            ($urandom_range(0, 7) == 0));
    end
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide unit and its sequencer. It sits beside the execute-stage ALU and owns the HI/LO registers. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO operation at a time from the decode-to-execute latch, and raises `busy` so the stall logic holds any following HI/LO-using instruction in decode. It also aborts an operation whose issuing instruction is flushed by an interrupt, so that the replay after `eret` cannot corrupt HI/LO.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU. Legal range 2..15.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU. Legal range 2..15.

- `clk` input 1: sole clock; all state changes on the rising edge.
- `reset` input 1: **asynchronous, active-low** reset.
- `start` input 1: operation request, qualified by `op`.
- `op` input 3: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is treated as NONE.
- `src0` input 32: rs value (multiplicand/dividend; MTHI/MTLO data).
- `src1` input 32: rt value (multiplier/divisor).
- `cancel` input 1: CP0 interrupt request (`int_req`).
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse when HI/LO commit a MULT/DIV result.
- `hi` output 32: HI register (MFHI source).
- `lo` output 32: LO register (MFLO source).

## Operation
- States are IDLE and RUN. Reset (`reset`=0, asynchronous) forces IDLE and clears `busy`, `done`, `hi`, `lo` and the internal counter and pending result to 0.
- **IDLE, rising edge with `start`=1 and `cancel`=0:**
  - MULT/MULTU/DIV/DIVU: compute the 64-bit result into pending HI/LO, load the counter with N (MULT_CYCLES or DIV_CYCLES), clear the elapsed flag, and go to RUN.
  - MTHI/MTLO: write `src0` into `hi`/`lo` at that edge. The state stays IDLE, and `busy` and `done` are not asserted.
  - NONE: no effect.
- `start` with `cancel`=1 is ignored in every state, because the issuing instruction is being flushed.
- **RUN:** the counter decrements each edge.
  - When it reaches 0, pending HI/LO are copied to `hi`/`lo`, `done` pulses for one cycle and the state returns to IDLE.
  - `start` in RUN is ignored. Upstream must stall; the bench checks that no state changes.
- **Cancel rule:**
  - `cancel`=1 on the first edge after issue (elapsed=0) aborts the operation: the state returns to IDLE, `hi`/`lo` keep their old values, and `done` is not pulsed. The issuing instruction sits in the memory stage and will be replayed.
  - `cancel` at any later edge is ignored, since the instruction has already committed.
- **Arithmetic:**
  - MULT: signed 32×32→64, `hi`=[63:32], `lo`=[31:0]. MULTU: unsigned.
  - DIV: signed, `lo`=quotient truncated toward zero, `hi`=remainder with the sign of the dividend. DIVU: unsigned.
  - Divisor 0: the operation runs its full N cycles and `done` pulses, but `hi`/`lo` are left unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
- Operands are latched at issue. Later changes on `src0`/`src1` have no effect.

## Timing
- Issue at edge k. `busy`=1 from edge k through edge k+N, i.e. high for exactly N cycles.
- At edge k+N: `busy` falls, `hi`/`lo` take the new values and `done` rises. `done` falls at edge k+N+1.
- A new `start` is accepted at edge k+N. Back-to-back operations therefore have no gap cycle.
- MTHI/MTLO: write latency is 1 edge. An MFHI issued the next cycle sees the new value.
- `hi`, `lo`, `busy` and `done` are direct register outputs with no combinational path from inputs.
- Reset asserted mid-RUN: all outputs are 0 immediately, without waiting for a clock edge. After release the state is IDLE and the first edge accepts `start`.

## Test plan
- **MULT/MULTU:** MULT 0xFFFFFFFF×0x00000002 → `busy` for 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE, and `done` pulses once. MULTU with the same operands → `hi`=0x00000001, `lo`=0xFFFFFFFE.
- **DIV/DIVU:**
  - DIV 0xFFFFFFF9/0x00000002 → after 10 cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU 7/0 → `busy` for 10 cycles, `done` pulses, `hi`/`lo` unchanged.
  - DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Cancel:**
  - MULT issued with `cancel`=1 on the same edge → `busy` never rises.
  - MULT issued, then `cancel`=1 on the next edge → `busy` drops after 1 cycle, `hi`/`lo` hold their old values and there is no `done`.
  - `cancel` at the third edge → the operation completes normally.
- **Busy/back-to-back:**
  - MTHI 0x12345678 while idle → `hi`=0x12345678 after 1 edge, `busy` stays 0.
  - `start` MTLO while MULT is running → ignored; `lo` takes only the MULT result.
  - MULT then immediate DIV at edge k+5 → `busy` stays high for 15 continuous cycles.
- **Reset:** pull `reset` low in cycle 3 of a DIV → `busy`, `done`, `hi` and `lo` are 0 asynchronously. After release, MULT 3×4 gives `lo`=12, `hi`=0.
